// File: rtl/data_sram_responder.sv
// Data-side responder for the MIPS M-stage SRAM port: word RAM with byte lanes
// plus an MMIO window (LED, switches, timer/compare, IRQ status). Read data has 1-cycle latency.
module data_sram_responder #(
   parameter int          ADDR_W    = 12,
   parameter logic [15:0] MMIO_BASE = 16'hBFAF,
   parameter int          SW_W      = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [3:0]      wen,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   input  logic [SW_W-1:0] switch_i,
   output logic [15:0]     led_o,
   output logic            timer_irq_o
);

   localparam logic [15:0] OFF_LED     = 16'hF000;
   localparam logic [15:0] OFF_SWITCH  = 16'hF004;
   localparam logic [15:0] OFF_COUNT   = 16'hE000;
   localparam logic [15:0] OFF_COMPARE = 16'hE004;
   localparam logic [15:0] OFF_STATUS  = 16'hE008;

   // Replace the byte lanes of old_word selected by mask with those of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   logic [31:0]       ram_r [0:(1<<ADDR_W)-1];
   logic [31:0]       rdata_r;
   logic [15:0]       led_r;
   logic [SW_W-1:0]   sw_meta_r;
   logic [SW_W-1:0]   sw_sync_r;
   logic [31:0]       count_r;
   logic [31:0]       compare_r;
   logic              pending_r;

   logic              mmio_sel_s;
   logic [15:0]       offset_s;
   logic [ADDR_W-1:0] ram_idx_s;
   logic              wr_s;
   logic              ram_wr_s;
   logic              led_wr_s;
   logic              count_wr_s;
   logic              compare_wr_s;
   logic              status_clr_s;
   logic              match_s;
   logic [31:0]       mmio_rd_s;
   logic [31:0]       count_next_s;
   logic              pending_next_s;

   assign mmio_sel_s = (addr[31:16] == MMIO_BASE);
   assign offset_s   = addr[15:0];
   assign ram_idx_s  = addr[ADDR_W+1:2];
   assign wr_s       = en && (wen != 4'b0000);

   // Address decode, MMIO read mux and timer next-state logic.
   always_comb begin
      ram_wr_s       = 1'b0;
      led_wr_s       = 1'b0;
      count_wr_s     = 1'b0;
      compare_wr_s   = 1'b0;
      status_clr_s   = 1'b0;
      mmio_rd_s      = 32'h0000_0000;
      count_next_s   = count_r + 32'd1;
      pending_next_s = pending_r;

      if (mmio_sel_s) begin
         case (offset_s)
            OFF_LED: begin
               led_wr_s  = wr_s;
               mmio_rd_s = {16'h0000, led_r};
            end
            OFF_SWITCH: begin
               mmio_rd_s = {{(32-SW_W){1'b0}}, sw_sync_r};
            end
            OFF_COUNT: begin
               count_wr_s = wr_s;
               mmio_rd_s  = count_r;
            end
            OFF_COMPARE: begin
               compare_wr_s = wr_s;
               mmio_rd_s    = compare_r;
            end
            OFF_STATUS: begin
               status_clr_s = wr_s && wen[0] && wdata[0];
               mmio_rd_s    = {31'h0000_0000, pending_r};
            end
            default: begin
               mmio_rd_s = 32'h0000_0000;
            end
         endcase
      end else begin
         ram_wr_s = wr_s;
      end

      // A COUNT write overrides the increment rather than adding to it.
      if (count_wr_s) begin
         count_next_s = merge_bytes(count_r, wdata, wen);
      end else begin
         count_next_s = count_r + 32'd1;
      end

      // A match on the old count/compare wins over a coincident clear.
      if (match_s) begin
         pending_next_s = 1'b1;
      end else if (status_clr_s) begin
         pending_next_s = 1'b0;
      end else begin
         pending_next_s = pending_r;
      end
   end

   assign match_s = (count_r == compare_r) && (compare_r != 32'h0000_0000);

   // RAM byte-lane writes; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ram_wr_s) begin
         ram_r[ram_idx_s] <= merge_bytes(ram_r[ram_idx_s], wdata, wen);
      end
   end

   // Registered read data, read-first with respect to a same-cycle write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r <= 32'h0000_0000;
      end else if (en) begin
         rdata_r <= mmio_sel_s ? mmio_rd_s : ram_r[ram_idx_s];
      end
   end

   // MMIO registers, switch synchroniser and timer state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_r     <= 16'h0000;
         sw_meta_r <= '0;
         sw_sync_r <= '0;
         count_r   <= 32'h0000_0000;
         compare_r <= 32'h0000_0000;
         pending_r <= 1'b0;
      end else begin
         sw_meta_r <= switch_i;
         sw_sync_r <= sw_meta_r;
         count_r   <= count_next_s;
         pending_r <= pending_next_s;
         if (led_wr_s) begin
            if (wen[0]) led_r[7:0]  <= wdata[7:0];
            if (wen[1]) led_r[15:8] <= wdata[15:8];
         end
         if (compare_wr_s) begin
            compare_r <= merge_bytes(compare_r, wdata, wen);
         end
      end
   end

   assign rdata       = rdata_r;
   assign led_o       = led_r;
   assign timer_irq_o = pending_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder: RAM lanes, read-first,
// MMIO LED/switch, counter wrap/priority, timer IRQ and asynchronous reset.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  switch_i;
   logic [15:0] led_o;
   logic        timer_irq_o;

   int checks = 0;
   int errors = 0;

   data_sram_responder #(.ADDR_W(12), .MMIO_BASE(16'hBFAF), .SW_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
      .rdata(rdata), .switch_i(switch_i), .led_o(led_o), .timer_irq_o(timer_irq_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      en = 1'b1; wen = w; addr = a; wdata = d;
      tick();
      en = 1'b0; wen = 4'b0000;
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
      checks++; if (led_o !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led_o, 16'h0); end
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq_o); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ram_bytes();
      access(32'h0000_0100, 4'b1111, 32'h1122_3344);
      access(32'h0000_0100, 4'b0010, 32'h0000_AA00);
      checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL ram_lane_readfirst: got %h expected %h", rdata, 32'h1122_3344); end
      access(32'h0000_0100, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h1122_AA44) begin errors++; $display("FAIL ram_lane_read: got %h expected %h", rdata, 32'h1122_AA44); end
      tick();
      checks++; if (rdata !== 32'h1122_AA44) begin errors++; $display("FAIL ram_hold: got %h expected %h", rdata, 32'h1122_AA44); end
   endtask

   task automatic test_read_during_write();
      access(32'h0000_0200, 4'b1111, 32'hDEAD_BEEF);
      access(32'h0000_0200, 4'b1111, 32'h1234_5678);
      checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdw_old: got %h expected %h", rdata, 32'hDEAD_BEEF); end
      access(32'h0000_0200, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdw_new: got %h expected %h", rdata, 32'h1234_5678); end
   endtask

   task automatic test_mmio();
      access(32'hBFAF_F000, 4'b1111, 32'hFFFF_00A5);
      checks++; if (led_o !== 16'h00A5) begin errors++; $display("FAIL led_out: got %h expected %h", led_o, 16'h00A5); end
      access(32'hBFAF_F000, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL led_read: got %h expected %h", rdata, 32'h0000_00A5); end
      switch_i = 8'h3C;
      tick(); tick();
      access(32'hBFAF_F004, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0000_003C) begin errors++; $display("FAIL switch_read: got %h expected %h", rdata, 32'h0000_003C); end
      access(32'hBFAF_F100, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0); end
   endtask

   task automatic test_counter();
      access(32'hBFAF_E000, 4'b1111, 32'hFFFF_FFFE);
      tick(); tick();
      access(32'hBFAF_E000, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h expected %h", rdata, 32'h0); end
      access(32'hBFAF_E000, 4'b1111, 32'h0000_1000);
      access(32'hBFAF_E000, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0000_1000) begin errors++; $display("FAIL count_write_exact: got %h expected %h", rdata, 32'h0000_1000); end
      access(32'hBFAF_E000, 4'b0001, 32'h0000_00FF);
      access(32'hBFAF_E000, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0000_10FF) begin errors++; $display("FAIL count_byte_write: got %h expected %h", rdata, 32'h0000_10FF); end
      access(32'hBFAF_E000, 4'b1111, 32'hFFFF_FFF0);
      repeat (40) tick();
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL compare_zero_irq: got %b expected 0", timer_irq_o); end
   endtask

   task automatic test_timer();
      access(32'hBFAF_E000, 4'b1111, 32'd1000);
      access(32'hBFAF_E004, 4'b1111, 32'd10);
      access(32'hBFAF_E004, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL compare_read: got %h expected %h", rdata, 32'd10); end
      access(32'hBFAF_E000, 4'b1111, 32'd0);
      repeat (10) tick();
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", timer_irq_o); end
      tick();
      checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", timer_irq_o); end
      repeat (5) tick();
      checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b expected 1", timer_irq_o); end
      access(32'hBFAF_E008, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL status_read: got %h expected %h", rdata, 32'h1); end
      access(32'hBFAF_E008, 4'b0001, 32'h0);
      checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL status_write0: got %b expected 1", timer_irq_o); end
      access(32'hBFAF_E008, 4'b0001, 32'h1);
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL status_clear: got %b expected 0", timer_irq_o); end
      access(32'hBFAF_E000, 4'b1111, 32'd5);
      repeat (5) tick();
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b expected 0", timer_irq_o); end
      access(32'hBFAF_E008, 4'b0001, 32'h1);
      checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b expected 1", timer_irq_o); end
   endtask

   task automatic test_async_reset();
      access(32'hBFAF_F000, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL pre_reset_read: got %h expected %h", rdata, 32'h0000_00A5); end
      #3 rst = 1'b0;
      #1;
      checks++; if (led_o !== 16'h0) begin errors++; $display("FAIL async_led: got %h expected %h", led_o, 16'h0); end
      checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL async_irq: got %b expected 0", timer_irq_o); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h expected %h", rdata, 32'h0); end
      tick();
      #3 rst = 1'b1;
      tick();
      access(32'h0000_0100, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h1122_AA44) begin errors++; $display("FAIL ram_after_reset: got %h expected %h", rdata, 32'h1122_AA44); end
      access(32'hBFAF_E004, 4'b0000, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL compare_after_reset: got %h expected %h", rdata, 32'h0); end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0; switch_i = 8'h00;
      test_reset();
      test_ram_bytes();
      test_read_during_write();
      test_mmio();
      test_counter();
      test_timer();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
